alu_pipe_n: RTL and testbench

Parametrised, registered successor to the team's 8-bit combinational ALU. It adds a WIDTH-generic datapath, a valid/ready handshake on input and output, shift operations, and an iterative shift-add unsigned multiplier. It sits between the operand-fetch stage and the result/flag register stage, and holds each result until the consumer takes it.

---
 rtl/alu_pipe_n_if.sv | 32 +++
 rtl/alu_pipe_n.sv | 186 ++++++++++++++++++
 tb/tb_alu_pipe_n.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_n_if.sv
// Request/result bundle for alu_pipe_n: valid/ready handshake on both sides
// plus operands, result and flags. The ALU uses the slave modport.
interface alu_pipe_n_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_hi;
  logic             cout;
  logic             zero;
  logic             sign;
  logic             overflow;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, opcode, a, b, cin, out_ready,
    input  in_ready, out_valid, res, res_hi, cout, zero, sign, overflow, illegal, busy
  );

  modport slave (
    input  in_valid, opcode, a, b, cin, out_ready,
    output in_ready, out_valid, res, res_hi, cout, zero, sign, overflow, illegal, busy
  );
endinterface

// File: rtl/alu_pipe_n.sv
// Registered WIDTH-generic ALU with valid/ready handshakes, shifts and an
// iterative shift-add unsigned multiplier; results hold until consumed.
module alu_pipe_n #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_pipe_n_if.slave  bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int MSB     = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR = 4'd4, OP_NOT = 4'd5, OP_INC = 4'd6, OP_DEC = 4'd7,
    OP_SHL = 4'd8, OP_SHR = 4'd9, OP_SAR = 4'd10, OP_MUL = 4'd11
  } op_e;

  state_e state, state_next;

  logic [WIDTH-1:0] op_a, op_b;
  logic             hs, is_mul, last_iter;

  assign op_a   = bus.a;
  assign op_b   = bus.b;
  assign is_mul = (bus.opcode == OP_MUL);

  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign hs            = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == BUSY);

  // Single-cycle result path, registered on handshake.
  logic [WIDTH-1:0]        s_res;
  logic                    s_cout, s_ovf, s_ill;
  logic [WIDTH:0]          wide;
  logic signed [WIDTH:0]   sar_tmp;
  logic [SHAMT_W-1:0]      sh;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    s_res   = '0;
    s_cout  = 1'b0;
    s_ovf   = 1'b0;
    s_ill   = 1'b0;
    wide    = '0;
    sar_tmp = '0;
    sh      = op_b[SHAMT_W-1:0];
    case (bus.opcode)
      OP_ADD: begin
        wide   = {1'b0, op_a} + {1'b0, op_b} + (WIDTH+1)'(bus.cin);
        s_res  = wide[MSB:0];
        s_cout = wide[WIDTH];
        s_ovf  = (op_a[MSB] == op_b[MSB]) & (s_res[MSB] != op_a[MSB]);
      end
      OP_SUB: begin
        wide   = {1'b0, op_a} - {1'b0, op_b} - (WIDTH+1)'(bus.cin);
        s_res  = wide[MSB:0];
        s_cout = wide[WIDTH];
        s_ovf  = (op_a[MSB] != op_b[MSB]) & (s_res[MSB] != op_a[MSB]);
      end
      OP_AND: s_res = op_a & op_b;
      OP_OR:  s_res = op_a | op_b;
      OP_XOR: s_res = op_a ^ op_b;
      OP_NOT: s_res = ~op_a;
      OP_INC: begin
        wide   = {1'b0, op_a} + (WIDTH+1)'(1);
        s_res  = wide[MSB:0];
        s_cout = wide[WIDTH];
        s_ovf  = ~op_a[MSB] & s_res[MSB];
      end
      OP_DEC: begin
        wide   = {1'b0, op_a} - (WIDTH+1)'(1);
        s_res  = wide[MSB:0];
        s_cout = wide[WIDTH];
        s_ovf  = op_a[MSB] & ~s_res[MSB];
      end
      // Shifts run on a one-bit-extended word so the extra bit is the last
      // bit shifted out (and stays 0 for a shift of zero).
      OP_SHL: begin
        wide   = {1'b0, op_a} << sh;
        s_res  = wide[MSB:0];
        s_cout = wide[WIDTH];
      end
      OP_SHR: begin
        wide   = {op_a, 1'b0} >> sh;
        s_res  = wide[WIDTH:1];
        s_cout = wide[0];
      end
      OP_SAR: begin
        sar_tmp = $signed({op_a, 1'b0}) >>> sh;
        s_res   = sar_tmp[WIDTH:1];
        s_cout  = sar_tmp[0];
      end
      OP_MUL: ;
      default: s_ill = 1'b1;
    endcase
  end

  // Shift-add multiplier state.
  logic [2*WIDTH-1:0] mcand, prod, prod_next;
  logic [WIDTH-1:0]   mplier;
  logic [SHAMT_W-1:0] cnt;

  assign prod_next = prod + (mplier[0] ? mcand : '0);
  assign last_iter = (cnt == SHAMT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hs) state_next = is_mul ? BUSY : DONE;
      BUSY:    if (last_iter) state_next = DONE;
      DONE: begin
        if (hs)                 state_next = is_mul ? BUSY : DONE;
        else if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  logic [WIDTH-1:0] res_q, res_hi_q;
  logic             cout_q, zero_q, sign_q, ovf_q, ill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      res_hi_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      cnt      <= '0;
    end else if (hs) begin
      if (is_mul) begin
        mcand  <= {{WIDTH{1'b0}}, op_a};
        mplier <= op_b;
        prod   <= '0;
        cnt    <= '0;
      end else begin
        res_q    <= s_res;
        res_hi_q <= '0;
        cout_q   <= s_cout;
        zero_q   <= (s_res == '0);
        sign_q   <= s_res[MSB];
        ovf_q    <= s_ovf;
        ill_q    <= s_ill;
      end
    end else if (state == BUSY) begin
      prod   <= prod_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + SHAMT_W'(1);
      // The final partial product goes straight to the outputs.
      if (last_iter) begin
        res_q    <= prod_next[MSB:0];
        res_hi_q <= prod_next[2*WIDTH-1:WIDTH];
        cout_q   <= 1'b0;
        zero_q   <= (prod_next == '0);
        sign_q   <= prod_next[MSB];
        ovf_q    <= |prod_next[2*WIDTH-1:WIDTH];
        ill_q    <= 1'b0;
      end
    end
  end

  assign bus.res      = res_q;
  assign bus.res_hi   = res_hi_q;
  assign bus.cout     = cout_q;
  assign bus.zero     = zero_q;
  assign bus.sign     = sign_q;
  assign bus.overflow = ovf_q;
  assign bus.illegal  = ill_q;
endmodule

// File: tb/tb_alu_pipe_n.sv
// Randomized and directed bench for alu_pipe_n against an integer-arithmetic
// reference model of the opcode table.
module tb_alu_pipe_n;
  localparam int W = 8;
  localparam int M = 1 << W;
  localparam int H = 1 << (W - 1);

  logic clk = 1'b0;
  logic rst_n;

  alu_pipe_n_if #(.WIDTH(W)) bus ();
  alu_pipe_n #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         cout;
    logic         zero;
    logic         sign;
    logic         ovf;
    logic         ill;
  } result_t;

  function automatic int to_signed(input int v);
    return (v >= H) ? v - M : v;
  endfunction

  function automatic result_t model(input int op, input int ai, input int bi, input int ci);
    result_t r;
    int sa, sb, s, ss, sh, p;
    r  = '0;
    sa = to_signed(ai);
    sb = to_signed(bi);
    sh = bi % W;
    p  = 0;
    case (op)
      0: begin s = ai + bi + ci; ss = sa + sb + ci;
               r.res = W'(s % M); r.cout = (s >= M); r.ovf = (ss >= H) || (ss < -H); end
      1: begin s = ai - bi - ci; ss = sa - sb - ci;
               r.res = W'((s + M) % M); r.cout = (s < 0); r.ovf = (ss >= H) || (ss < -H); end
      2: r.res = W'(ai & bi);
      3: r.res = W'(ai | bi);
      4: r.res = W'(ai ^ bi);
      5: r.res = W'(M - 1 - ai);
      6: begin r.res = W'((ai + 1) % M); r.cout = (ai == M - 1); r.ovf = (ai == H - 1); end
      7: begin r.res = W'((ai + M - 1) % M); r.cout = (ai == 0); r.ovf = (ai == H); end
      8: begin r.res = W'((ai << sh) % M); r.cout = (sh != 0) && (((ai >> (W - sh)) & 1) == 1); end
      9: begin r.res = W'(ai >> sh); r.cout = (sh != 0) && (((ai >> (sh - 1)) & 1) == 1); end
      10: begin s = sa >>> sh; r.res = W'((s + M) % M);
                r.cout = (sh != 0) && (((ai >> (sh - 1)) & 1) == 1); end
      11: begin p = ai * bi; r.res = W'(p % M); r.hi = W'(p / M); r.ovf = (p >= M); end
      default: r.ill = 1'b1;
    endcase
    r.zero = (op == 11) ? (p == 0) : (r.res == '0);
    r.sign = r.res[W-1];
    return r;
  endfunction

  function automatic result_t observed();
    return {bus.res, bus.res_hi, bus.cout, bus.zero, bus.sign, bus.overflow, bus.illegal};
  endfunction

  task automatic drive(input int op, input int a, input int b, input int ci);
    bus.opcode   = op[3:0];
    bus.a        = a[W-1:0];
    bus.b        = b[W-1:0];
    bus.cin      = ci[0];
    bus.in_valid = 1'b1;
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_op(input string tag, input int op, input int a, input int b, input int ci);
    int n, lat;
    drive(op, a, b, ci);
    bus.out_ready = 1'b1;
    #1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_hs"}, bus.in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      if (op == 11) begin
        check({tag, "_busy"}, {bus.busy, bus.in_ready}, 2'b10);
      end
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, (op == 11) ? W + 1 : 1);
    check(tag, observed(), model(op, a, b, ci));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    result_t exp_xor;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.opcode    = '0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    #12;
    check("rst_outs", observed(), '0);
    check("rst_ctl", {bus.out_valid, bus.busy, bus.in_ready}, 3'b001);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD into signed overflow
    run_op("add_7f_01", 0, 'h7F, 'h01, 0);
    check("add_res", bus.res, 8'h80);

    // SUB then INC back-to-back
    @(negedge clk);
    drive(1, 'h00, 'h01, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("b2b_sub", observed(), model(1, 'h00, 'h01, 0));
    check("b2b_sub_rdy", {bus.out_valid, bus.in_ready}, 2'b11);
    drive(6, 'hFF, 'h00, 0);
    @(negedge clk);
    check("b2b_inc", observed(), model(6, 'hFF, 'h00, 0));
    check("b2b_inc_rdy", {bus.out_valid, bus.in_ready}, 2'b11);
    bus.in_valid = 1'b0;

    // Multiplier corner
    run_op("mul_ff_ff", 11, 'hFF, 'hFF, 0);
    check("mul_hi", bus.res_hi, 8'hFE);

    // Shifts
    run_op("sar_90_3", 10, 'h90, 3, 0);
    check("sar_res", bus.res, 8'hF2);
    run_op("shl_81_1", 8, 'h81, 1, 0);
    run_op("shr_5a_0", 9, 'h5A, 0, 1);

    // Back-pressure: XOR result held while a new request waits
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    drive(4, 'hAA, 'hFF, 0);
    bus.out_ready = 1'b0;
    exp_xor = model(4, 'hAA, 'hFF, 0);
    @(negedge clk);
    drive(2, 'h0F, 'h3C, 0);
    for (int i = 0; i < 5; i++) begin
      check("hold_xor", observed(), exp_xor);
      check("hold_ctl", {bus.out_valid, bus.in_ready}, 2'b10);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_rdy", bus.in_ready, 1'b1);
    @(negedge clk);
    check("release_and", observed(), model(2, 'h0F, 'h3C, 0));
    bus.in_valid = 1'b0;

    // Reset in the middle of a multiply
    drive(11, 'hC3, 'h5D, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_mul_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", observed(), '0);
    check("mid_rst_ctl", {bus.out_valid, bus.busy, bus.in_ready}, 3'b001);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("illegal_13", 13, 'h12, 'h34, 1);

    // Randomized mix, including illegal opcodes
    for (int i = 0; i < 300; i++) begin
      run_op("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, M - 1)),
             int'($urandom_range(0, M - 1)), int'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
